// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad entry block.
//   scan_state_e : scanner FSM states
//   KEY_*        : 4-bit key codes (digits use their own BCD value)
//   keymap()     : (row index, column index) -> key code
//   low_row()    : index of the lowest-numbered low row in an active-low pattern
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} scan_state_e;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = KEY_1;    4'h1: k = KEY_2;    4'h2: k = KEY_3;    4'h3: k = KEY_A;
      4'h4: k = KEY_4;    4'h5: k = KEY_5;    4'h6: k = KEY_6;    4'h7: k = KEY_B;
      4'h8: k = KEY_7;    4'h9: k = KEY_8;    4'hA: k = KEY_9;    4'hB: k = KEY_C;
      4'hC: k = KEY_STAR; 4'hD: k = KEY_0;    4'hE: k = KEY_HASH; default: k = KEY_D;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] rs);
    logic [1:0] r;
    if (!rs[0])      r = 2'd0;
    else if (!rs[1]) r = 2'd1;
    else if (!rs[2]) r = 2'd2;
    else             r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry_scanner.sv
// Keypad scanner: row synchronizer, one-hot column drive, scan/debounce FSM.
//   clk, rst  : clock, synchronous active-high reset
//   row       : raw active-low rows (asynchronous)
//   col       : active-low one-hot column drive
//   key_code  : code of the accepted key (valid with key_stb)
//   key_stb   : single-cycle strobe, combinational, on the accepting edge
module keypad_entry_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_stb
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

  logic [3:0]       row_meta_q, rs_q;
  scan_state_e      state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       key_q, key_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      // idle rows read high, so reset the synchronizer to "no key"
      row_meta_q <= 4'hF;
      rs_q       <= 4'hF;
      state_q    <= SCAN;
      col_idx_q  <= 2'd0;
      div_q      <= '0;
      deb_q      <= '0;
      pat_q      <= 4'hF;
      key_q      <= 4'h0;
    end else begin
      row_meta_q <= row;
      rs_q       <= row_meta_q;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      div_q      <= div_d;
      deb_q      <= deb_d;
      pat_q      <= pat_d;
      key_q      <= key_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    div_d     = div_q;
    deb_d     = deb_q;
    pat_d     = pat_q;
    key_d     = key_q;
    key_stb   = 1'b0;
    case (state_q)
      SCAN: begin
        // sample only on the last dwell cycle so the synchronizer has
        // settled on this column's rows
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (rs_q != 4'hF) begin
            pat_d   = rs_q;
            key_d   = keymap(low_row(rs_q), col_idx_q);
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs_q == pat_q) begin
          if (deb_q == DEB_LAST) begin
            key_stb = 1'b1;
            state_d = HOLD;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          state_d   = SCAN;
          col_idx_d = col_idx_q + 2'd1;
          div_d     = '0;
        end
      end
      HOLD: begin
        if (rs_q == 4'hF) begin
          deb_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // any bounce back low re-arms the hold without re-issuing the key
        if (rs_q != 4'hF) begin
          state_d = HOLD;
        end else if (deb_q == DEB_LAST) begin
          state_d   = SCAN;
          col_idx_d = col_idx_q + 2'd1;
          div_d     = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign col      = ~(4'b0001 << col_idx_q);
  assign key_code = key_q;

endmodule

// File: rtl/keypad_entry.sv
// 4-digit BCD keypad entry with commit, backspace, clear and mode toggle.
//   clk, rst : clock, synchronous active-high reset
//   row/col  : keypad matrix (active-low)
//   entry    : live BCD entry, newest digit in [3:0]
//   count    : digits entered, 0..4
//   value    : committed BCD preset
//   load     : one-cycle pulse after value is updated
//   mode     : 0 counter, 1 timer
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int          SCAN_DIV     = 4,
  parameter int          DEBOUNCE_CYC = 8,
  parameter logic [15:0] RESET_VALUE  = 16'h9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] entry,
  output logic [2:0]  count,
  output logic [15:0] value,
  output logic        load,
  output logic        mode
);

  logic [3:0]  key_code;
  logic        key_stb;
  logic [15:0] entry_q, entry_d, value_q, value_d;
  logic [2:0]  count_q, count_d;
  logic        load_q, load_d, mode_q, mode_d;

  keypad_entry_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .row     (row),
    .col     (col),
    .key_code(key_code),
    .key_stb (key_stb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= 16'h0000;
      count_q <= 3'd0;
      value_q <= RESET_VALUE;
      load_q  <= 1'b0;
      mode_q  <= 1'b1;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      value_q <= value_d;
      load_q  <= load_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    value_d = value_q;
    load_d  = 1'b0;
    mode_d  = mode_q;
    if (key_stb) begin
      if (key_code <= KEY_9) begin
        // a fifth digit shifts the oldest one out
        entry_d = {entry_q[11:0], key_code};
        count_d = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
      end else begin
        case (key_code)
          KEY_A: begin
            entry_d = {4'h0, entry_q[15:4]};
            count_d = (count_q == 3'd0) ? 3'd0 : count_q - 3'd1;
          end
          KEY_STAR: begin
            entry_d = 16'h0000;
            count_d = 3'd0;
          end
          KEY_HASH: begin
            if (count_q != 3'd0) begin
              value_d = entry_q;
              load_d  = 1'b1;
              entry_d = 16'h0000;
              count_d = 3'd0;
            end
          end
          KEY_D:   mode_d = ~mode_q;
          default: ;
        endcase
      end
    end
  end

  assign entry = entry_q;
  assign count = count_q;
  assign value = value_q;
  assign load  = load_q;
  assign mode  = mode_q;

endmodule
